// File: rtl/issue_warp_arbiter_if.sv
// Issue-slice arbiter bundle: warp requests in, one registered beat out.
// master drives requests and downstream ready; slave is the arbiter.
interface issue_warp_arbiter_if #(
  parameter int NUM_WARPS     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int PERF_CTR_BITS = 44
);
  localparam int WW = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0]            in_valid;
  logic [NUM_WARPS*DATA_WIDTH-1:0] in_data;
  logic [NUM_WARPS-1:0]            in_eop;
  logic [NUM_WARPS-1:0]            in_ready;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [WW-1:0]                   out_wis;
  logic                            out_eop;
  logic                            out_ready;
  logic [PERF_CTR_BITS-1:0]        perf_stalls;

  modport master (
    output in_valid, in_data, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_wis,
    input  out_eop, perf_stalls
  );

  modport slave (
    input  in_valid, in_data, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_wis,
    output out_eop, perf_stalls
  );
endinterface

// File: rtl/issue_warp_arbiter.sv
// Round-robin warp picker feeding a one-entry operand-stage register.
// Multi-beat instructions lock the grant to one warp until eop.
module issue_warp_arbiter #(
  parameter int NUM_WARPS     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int PERF_CTR_BITS = 44
) (
  input logic clk,
  input logic reset,
  issue_warp_arbiter_if.slave arb
);
  localparam int WW = $clog2(NUM_WARPS);

  logic [WW-1:0]            rr_ptr;
  logic                     locked;
  logic [WW-1:0]            lock_wid;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [WW-1:0]            out_wis;
  logic                     out_eop;
  logic [PERF_CTR_BITS-1:0] perf_stalls;

  logic                  stage_free;
  logic                  found;
  logic                  fire;
  logic [WW-1:0]         win;
  logic [WW-1:0]         idx;
  logic [NUM_WARPS-1:0]  grant;
  logic                  win_eop;
  logic [DATA_WIDTH-1:0] win_data;

  always_comb begin
    stage_free = !out_valid || arb.out_ready;
    found = 1'b0;
    win = '0;
    idx = '0;
    if (locked) begin
      found = arb.in_valid[lock_wid];
      win = lock_wid;
    end else begin
      // scan starts just past the last eop winner
      for (int i = 1; i <= NUM_WARPS; i++) begin
        idx = rr_ptr + WW'(i);
        if (!found && arb.in_valid[idx]) begin
          found = 1'b1;
          win = idx;
        end
      end
    end
    fire = found && stage_free && !reset;
    grant = '0;
    if (fire) grant[win] = 1'b1;
    win_eop = arb.in_eop[win];
    win_data = arb.in_data[win*DATA_WIDTH +: DATA_WIDTH];
  end

  assign arb.in_ready    = grant;
  assign arb.out_valid   = out_valid;
  assign arb.out_data    = out_data;
  assign arb.out_wis     = out_wis;
  assign arb.out_eop     = out_eop;
  assign arb.perf_stalls = perf_stalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= WW'(NUM_WARPS - 1);
      locked      <= 1'b0;
      lock_wid    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_wis     <= '0;
      out_eop     <= 1'b0;
      perf_stalls <= '0;
    end else begin
      if (fire) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_wis   <= win;
        out_eop   <= win_eop;
        if (win_eop) begin
          locked <= 1'b0;
          rr_ptr <= win;
        end else begin
          locked   <= 1'b1;
          lock_wid <= win;
        end
      end else if (arb.out_ready) begin
        out_valid <= 1'b0;
      end
      if (|arb.in_valid && !fire)
        perf_stalls <= perf_stalls + 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) $onehot0(arb.in_ready));
  a_hold: assert property (@(posedge clk) disable iff (reset)
    out_valid && !arb.out_ready |=> $stable(out_data) && $stable(out_wis));
  a_lock: assert property (@(posedge clk)
    {1'b0, lock_wid} < (WW+1)'(NUM_WARPS));
`endif
endmodule

// File: tb/tb_issue_warp_arbiter.sv
// Directed bench for issue_warp_arbiter: round-robin, lock, stall, reset.
// Expected values are hand-derived per vector.
module tb_issue_warp_arbiter;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  issue_warp_arbiter_if #(
    .NUM_WARPS(4), .DATA_WIDTH(64), .PERF_CTR_BITS(44)
  ) arb ();

  issue_warp_arbiter #(
    .NUM_WARPS(4), .DATA_WIDTH(64), .PERF_CTR_BITS(44)
  ) dut (
    .clk(clk),
    .reset(reset),
    .arb(arb)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int w, input logic [63:0] v);
    arb.in_data[w*64 +: 64] = v;
  endtask

  function automatic logic [63:0] dval(input int w);
    return 64'hD000 + 64'(w);
  endfunction

  initial begin
    int seq [3];
    reset = 1'b1;
    arb.in_valid = '0;
    arb.in_eop = '0;
    arb.in_data = '0;
    arb.out_ready = 1'b1;
    for (int w = 0; w < 4; w++) set_data(w, dval(w));
    step();
    step();
    chk("rst_out_valid", 64'(arb.out_valid), 0);
    chk("rst_out_data", arb.out_data, 0);
    chk("rst_out_wis", 64'(arb.out_wis), 0);
    chk("rst_out_eop", 64'(arb.out_eop), 0);
    chk("rst_perf", 64'(arb.perf_stalls), 0);
    arb.in_valid = 4'b1111;
    arb.in_eop = 4'b1111;
    #1;
    chk("rst_in_ready", 64'(arb.in_ready), 0);
    step();
    reset = 1'b0;

    // all warps valid: w0,w1,w2,w3,w0
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 64'(arb.in_ready), 64'(4'b0001 << (k % 4)));
      step();
      chk("rr_valid", 64'(arb.out_valid), 1);
      chk("rr_wis", 64'(arb.out_wis), 64'(k % 4));
      chk("rr_data", arb.out_data, dval(k % 4));
    end
    chk("rr_perf", 64'(arb.perf_stalls), 0);

    // w1,w3 only
    arb.in_valid = 4'b1010;
    seq = '{1, 3, 1};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("alt_ready", 64'(arb.in_ready), 64'(4'b0001 << seq[k]));
      step();
      chk("alt_wis", 64'(arb.out_wis), 64'(seq[k]));
    end
    chk("alt_perf", 64'(arb.perf_stalls), 0);

    // w2 three-beat packet while w0,w1 wait
    arb.in_valid = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      arb.in_eop = (b == 2) ? 4'b1111 : 4'b1011;
      set_data(2, 64'hB0 + 64'(b));
      #1;
      chk("pkt_ready", 64'(arb.in_ready), 64'(4'b0100));
      step();
      chk("pkt_wis", 64'(arb.out_wis), 2);
      chk("pkt_eop", 64'(arb.out_eop), (b == 2) ? 64'd1 : 64'd0);
      chk("pkt_data", arb.out_data, 64'hB0 + 64'(b));
    end
    #1;
    chk("pkt_next_ready", 64'(arb.in_ready), 64'(4'b0001));
    step();
    chk("pkt_next_wis", 64'(arb.out_wis), 0);
    chk("pkt_perf", 64'(arb.perf_stalls), 0);

    // downstream backpressure for 5 cycles
    arb.in_valid = 4'b0001;
    arb.out_ready = 1'b0;
    set_data(0, 64'hE0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 64'(arb.in_ready), 0);
      step();
      chk("bp_valid", 64'(arb.out_valid), 1);
      chk("bp_wis", 64'(arb.out_wis), 0);
      chk("bp_data", arb.out_data, dval(0));
    end
    chk("bp_perf", 64'(arb.perf_stalls), 5);
    arb.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(arb.in_ready), 64'(4'b0001));
    step();
    chk("bp_release_data", arb.out_data, 64'hE0);
    chk("bp_release_perf", 64'(arb.perf_stalls), 5);

    // lock on w1, w1 drops out for 3 cycles
    arb.in_valid = 4'b0011;
    arb.in_eop = 4'b1101;
    #1;
    chk("lk_ready", 64'(arb.in_ready), 64'(4'b0010));
    step();
    chk("lk_wis", 64'(arb.out_wis), 1);
    chk("lk_eop", 64'(arb.out_eop), 0);
    arb.in_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lk_idle_ready", 64'(arb.in_ready), 0);
      step();
    end
    chk("lk_idle_valid", 64'(arb.out_valid), 0);
    chk("lk_perf", 64'(arb.perf_stalls), 8);
    arb.in_valid = 4'b0011;
    arb.in_eop = 4'b1111;
    #1;
    chk("lk_eop_ready", 64'(arb.in_ready), 64'(4'b0010));
    step();
    chk("lk_eop_wis", 64'(arb.out_wis), 1);
    chk("lk_eop_eop", 64'(arb.out_eop), 1);
    #1;
    chk("lk_after_ready", 64'(arb.in_ready), 64'(4'b0001));
    step();
    chk("lk_after_wis", 64'(arb.out_wis), 0);
    chk("lk_after_perf", 64'(arb.perf_stalls), 8);

    // reset in the middle of a locked w3 packet
    arb.in_valid = 4'b1000;
    arb.in_eop = 4'b0111;
    #1;
    chk("mr_ready", 64'(arb.in_ready), 64'(4'b1000));
    step();
    chk("mr_wis", 64'(arb.out_wis), 3);
    chk("mr_valid", 64'(arb.out_valid), 1);
    reset = 1'b1;
    #1;
    chk("mr_rst_ready", 64'(arb.in_ready), 0);
    step();
    chk("mr_rst_valid", 64'(arb.out_valid), 0);
    chk("mr_rst_perf", 64'(arb.perf_stalls), 0);
    reset = 1'b0;
    arb.in_valid = 4'b1001;
    arb.in_eop = 4'b1111;
    #1;
    chk("mr_first_ready", 64'(arb.in_ready), 64'(4'b0001));
    step();
    chk("mr_first_wis", 64'(arb.out_wis), 0);
    chk("mr_first_valid", 64'(arb.out_valid), 1);
    #1;
    chk("mr_second_ready", 64'(arb.in_ready), 64'(4'b1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
